// File: rtl/simon_sequence_generator.sv
// Symbol source for the two-button Simon game: a free-running entropy LFSR supplies
// seeds, and a replay LFSR regenerates the same symbol stream after every rewind.
module simon_sequence_generator #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              randomize,
  input  logic              start_over,
  input  logic              next,
  input  logic [1:0]        entropy_in,
  output logic [7:0]        seq_out,
  output logic              seq_valid,
  output logic [4:0]        step_count,
  output logic [LFSR_W-1:0] seed
);

  localparam logic [4:0] STEP_MAX = 5'd31;

  logic [LFSR_W-1:0] r_ent;
  logic [LFSR_W-1:0] r_rep;
  logic [LFSR_W-1:0] r_seed;
  logic [7:0]        r_seq_out;
  logic              r_seq_valid;
  logic [4:0]        r_step_count;

  logic              w_rep_fb;
  logic              w_ent_fb;
  logic [LFSR_W-1:0] w_rep_step;
  logic [LFSR_W-1:0] w_ent_step;
  logic [LFSR_W-1:0] w_ent_next;
  logic [LFSR_W-1:0] w_capture;

  // Both LFSRs share the x^16+x^14+x^13+x^11+1 taps; entropy also folds in button levels.
  assign w_rep_fb   = r_rep[15] ^ r_rep[13] ^ r_rep[12] ^ r_rep[10];
  assign w_ent_fb   = r_ent[15] ^ r_ent[13] ^ r_ent[12] ^ r_ent[10] ^ entropy_in[0] ^ entropy_in[1];
  assign w_rep_step = {r_rep[LFSR_W-2:0], w_rep_fb};
  assign w_ent_step = {r_ent[LFSR_W-2:0], w_ent_fb};

  // Button mixing can drive the entropy LFSR into the all-zero lock-up state; escape it.
  assign w_ent_next = (w_ent_step == '0) ? SEED_DEFAULT : w_ent_step;
  assign w_capture  = (r_ent == '0) ? SEED_DEFAULT : r_ent;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ent        <= SEED_DEFAULT;
      r_rep        <= SEED_DEFAULT;
      r_seed       <= SEED_DEFAULT;
      r_seq_out    <= 8'h00;
      r_seq_valid  <= 1'b0;
      r_step_count <= 5'd0;
    end else begin
      r_ent <= w_ent_next;
      if (randomize) begin
        r_seed       <= w_capture;
        r_rep        <= w_capture;
        r_seq_out    <= 8'h00;
        r_seq_valid  <= 1'b0;
        r_step_count <= 5'd0;
      end else if (start_over) begin
        r_rep        <= r_seed;
        r_seq_out    <= 8'h00;
        r_seq_valid  <= 1'b0;
        r_step_count <= 5'd0;
      end else if (next) begin
        r_rep        <= w_rep_step;
        r_seq_out    <= {6'd0, w_rep_fb, ~w_rep_fb};
        r_seq_valid  <= 1'b1;
        if (r_step_count != STEP_MAX) begin
          r_step_count <= r_step_count + 5'd1;
        end
      end
    end
  end

  assign seq_out    = r_seq_out;
  assign seq_valid  = r_seq_valid;
  assign step_count = r_step_count;
  assign seed       = r_seed;

endmodule

// File: tb/tb_simon_sequence_generator.sv
// Directed bench for simon_sequence_generator: a reference model pushes expected outputs
// into a scoreboard queue as each command is driven; they are popped after the edge.
module tb_simon_sequence_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        randomize;
  logic        start_over;
  logic        next;
  logic [1:0]  entropy_in;
  logic [7:0]  seq_out;
  logic        seq_valid;
  logic [4:0]  step_count;
  logic [15:0] seed;

  always #5 clk = ~clk;

  simon_sequence_generator dut (
    .clk        (clk),
    .reset      (reset),
    .randomize  (randomize),
    .start_over (start_over),
    .next       (next),
    .entropy_in (entropy_in),
    .seq_out    (seq_out),
    .seq_valid  (seq_valid),
    .step_count (step_count),
    .seed       (seed)
  );

  typedef struct {
    string       tag;
    logic [7:0]  out;
    logic        valid;
    logic [4:0]  cnt;
    logic [15:0] seed;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_ent  = 1'b0;

  logic [15:0] m_ent;
  logic [15:0] m_rep;
  logic [15:0] m_seed;
  logic [7:0]  m_out;
  logic        m_valid;
  logic [4:0]  m_cnt;

  function automatic logic [15:0] lfsr(input logic [15:0] s, input logic [1:0] e);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ e[0] ^ e[1]};
  endfunction

  function automatic logic [15:0] ent_next(input logic [15:0] s, input logic [1:0] e);
    logic [15:0] t;
    t = lfsr(s, e);
    return (t == 16'h0000) ? 16'hACE1 : t;
  endfunction

  // Entropy reference runs alongside the DUT, sampling the same inputs each edge.
  always @(posedge clk) begin
    if (!reset) m_ent <= 16'hACE1;
    else        m_ent <= ent_next(m_ent, entropy_in);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input string tag);
    exp_t e;
    e.tag   = tag;
    e.out   = m_out;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    e.seed  = m_seed;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".seq_out"},    seq_out,    e.out);
    chk({e.tag, ".seq_valid"},  seq_valid,  e.valid);
    chk({e.tag, ".step_count"}, step_count, e.cnt);
    chk({e.tag, ".seed"},       seed,       e.seed);
  endtask

  // One clocked command; priority randomize > start_over > next in the model.
  task automatic cmd(input string tag, input logic r, input logic s, input logic n);
    logic [15:0] cap;
    randomize  = r;
    start_over = s;
    next       = n;
    if (rnd_ent) entropy_in = 2'($urandom_range(0, 3));
    if (r) begin
      cap     = (m_ent == 16'h0000) ? 16'hACE1 : m_ent;
      m_seed  = cap;
      m_rep   = cap;
      m_out   = 8'h00;
      m_valid = 1'b0;
      m_cnt   = 5'd0;
    end else if (s) begin
      m_rep   = m_seed;
      m_out   = 8'h00;
      m_valid = 1'b0;
      m_cnt   = 5'd0;
    end else if (n) begin
      m_rep   = lfsr(m_rep, 2'b00);
      m_out   = m_rep[0] ? 8'h02 : 8'h01;
      m_valid = 1'b1;
      m_cnt   = (m_cnt == 5'd31) ? 5'd31 : m_cnt + 5'd1;
    end
    push_model(tag);
    @(posedge clk);
    #1;
    randomize  = 1'b0;
    start_over = 1'b0;
    next       = 1'b0;
    pop_check();
  endtask

  task automatic do_reset(input string tag, input logic with_next);
    reset   = 1'b0;
    next    = with_next;
    m_rep   = 16'hACE1;
    m_seed  = 16'hACE1;
    m_out   = 8'h00;
    m_valid = 1'b0;
    m_cnt   = 5'd0;
    push_model(tag);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    next  = 1'b0;
    pop_check();
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  logic [7:0] p_exp [4] = '{8'h02, 8'h02, 8'h02, 8'h01};

  initial begin
    reset      = 1'b0;
    randomize  = 1'b0;
    start_over = 1'b0;
    next       = 1'b0;
    entropy_in = 2'b00;

    do_reset("reset0", 1'b0);

    // First pass from the default seed, with idle gaps between steps.
    cmd("so1", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cmd("pass1", 1'b0, 1'b0, 1'b1);
      chk("pass1_lit", seq_out, p_exp[i]);
      chk("pass1_cnt", step_count, 32'(i + 1));
      idle(2);
    end
    for (int i = 0; i < 3; i++) cmd("more", 1'b0, 1'b0, 1'b1);
    cmd("so2", 1'b0, 1'b1, 1'b0);
    chk("so2_cnt", step_count, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cmd("pass2", 1'b0, 1'b0, 1'b1);
      chk("pass2_lit", seq_out, p_exp[i]);
    end

    // Randomize one cycle after reset release with quiet buttons.
    entropy_in = 2'b00;
    do_reset("reset1", 1'b0);
    idle(1);
    cmd("rand0", 1'b1, 1'b0, 1'b0);
    chk("rand0_seed_lit", seed, 32'h59C3);
    cmd("rand0_next", 1'b0, 1'b0, 1'b1);
    chk("rand0_next_lit", seq_out, 32'h02);

    // Same timing with button activity: seed must differ.
    entropy_in = 2'b01;
    do_reset("reset2", 1'b0);
    idle(1);
    cmd("rand1", 1'b1, 1'b0, 1'b0);
    n_checks++;
    assert (seed !== 16'h59C3) else begin
      n_fail++;
      $error("FAIL rand1_differs: observed %0h expected not 59c3", seed);
    end

    // Replay with noisy buttons must follow the latched seed.
    rnd_ent = 1'b1;
    for (int i = 0; i < 3; i++) cmd("noisy", 1'b0, 1'b0, 1'b1);
    cmd("so3", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cmd("noisy_replay", 1'b0, 1'b0, 1'b1);
    idle(3);

    // Coincident commands: only randomize acts.
    cmd("all3", 1'b1, 1'b1, 1'b1);
    chk("all3_cnt", step_count, 32'd0);
    cmd("all3_follow", 1'b0, 1'b0, 1'b1);

    // Saturation over 35 symbols.
    cmd("so4", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 35; i++) cmd("sat", 1'b0, 1'b0, 1'b1);
    chk("sat_cnt", step_count, 32'd31);

    // Held start_over acts like a single rewind.
    start_over = 1'b1;
    idle(2);
    cmd("held_so", 1'b0, 1'b1, 1'b0);
    cmd("held_so_next", 1'b0, 1'b0, 1'b1);

    // Reset mid-sequence with next held high.
    rnd_ent = 1'b0;
    for (int i = 0; i < 5; i++) cmd("pre_rst", 1'b0, 1'b0, 1'b1);
    do_reset("reset_mid", 1'b1);
    chk("reset_mid_seed", seed, 32'hACE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
